atctlc2axi500_hs_tx: RTL and testbench

Source-domain (transmitter) end of a 2-phase toggle request/acknowledge CDC handshake carrying a multi-bit payload.
- Accepts one word per valid/ready transfer in clk domain, holds it stable on xfer_data and toggles the req level toward the destination domain.
- Synchronizes the returned ack level into clk and frees for the next word once ack matches req.
- Sits at the clk-domain edge of TLC-to-AXI crossings; the destination end samples req through a level synchronizer.

---
 rtl/atctlc2axi500_hs_tx.sv | 95 +++++++++
 tb/tb_atctlc2axi500_hs_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/atctlc2axi500_hs_tx.sv
// atctlc2axi500_hs_tx: source end of a 2-phase toggle req/ack CDC handshake with held multi-bit payload
module atctlc2axi500_hs_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int SYNC_STAGE = 2,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  ack,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);
  if (SYNC_STAGE < 2) begin : g_bad_sync
    $error("atctlc2axi500_hs_tx: SYNC_STAGE must be >= 2");
  end
  typedef enum logic [1:0] {RST_WAIT, IDLE, WAIT_ACK} state_t;
  state_t state_q, state_d;
  logic src_ready_q, src_ready_d, busy_q, busy_d, done_q, done_d;
  logic err_q, err_d, req_q, req_d, ack_prev_q;
  logic [DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;
  logic [SYNC_STAGE-1:0] ack_sync_q, ack_sync_d;
  logic ack_s;
  assign ack_s = ack_sync_q[SYNC_STAGE-1];
  assign ack_sync_d = {ack_sync_q[SYNC_STAGE-2:0], ack};
  always_comb begin
    state_d     = state_q;
    src_ready_d = src_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    req_d       = req_q;
    xfer_data_d = xfer_data_q;
    case (state_q)
      RST_WAIT: begin
        src_ready_d = 1'b1;
        state_d     = IDLE;
      end
      IDLE: begin
        // any ack edge while nothing is outstanding is a destination fault
        err_d = err_q | (ack_s != ack_prev_q);
        if (src_valid && src_ready_q) begin
          xfer_data_d = src_data;
          req_d       = ~req_q;
          src_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) begin
          done_d      = 1'b1;
          busy_d      = 1'b0;
          src_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = RST_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RST_WAIT;
      src_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      xfer_data_q <= DATA_RESET;
      ack_sync_q  <= '0;
      ack_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ready_q <= src_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_q       <= req_d;
      xfer_data_q <= xfer_data_d;
      ack_sync_q  <= ack_sync_d;
      ack_prev_q  <= ack_s;
    end
  end
  assign src_ready = src_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req       = req_q;
  assign xfer_data = xfer_data_q;
endmodule

// File: tb/tb_atctlc2axi500_hs_tx.sv
// tb_atctlc2axi500_hs_tx: directed self-checking bench for the toggle handshake transmitter
module tb_atctlc2axi500_hs_tx;
  logic clk = 1'b0, resetn = 1'b0, src_valid = 1'b0, ack = 1'b0;
  logic [31:0] src_data = '0;
  logic src_ready, req, done, busy, err;
  logic [31:0] xfer_data;
  int checks = 0, failures = 0, done_cnt = 0;
  logic exp_req;
  atctlc2axi500_hs_tx dut (
    .clk(clk), .resetn(resetn), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .req(req), .xfer_data(xfer_data), .ack(ack),
    .done(done), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset;
    resetn = 1'b0; ack = 1'b0; src_valid = 1'b0; src_data = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick;
    exp_req = 1'b0;
  endtask
  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req); end
    checks++; if (xfer_data !== 32'h0) begin failures++; $display("FAIL reset_xfer_data got=%h exp=0", xfer_data); end
    checks++; if (src_ready !== 1'b0) begin failures++; $display("FAIL reset_src_ready got=%b exp=0", src_ready); end
    checks++; if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", busy, err, done); end
    resetn = 1'b1;
    checks++; if (src_ready !== 1'b0) begin failures++; $display("FAIL post_reset_ready1 got=%b exp=0", src_ready); end
    tick;
    checks++; if (src_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready2 got=%b exp=1", src_ready); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL post_reset_flags got=%b%b exp=00", busy, err); end
    exp_req = 1'b0;
  endtask
  task automatic test_single;
    src_valid = 1'b1; src_data = 32'hA5A5_0001;
    tick;
    src_valid = 1'b0; src_data = 32'h0;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", req); end
    checks++; if (xfer_data !== 32'hA5A5_0001) begin failures++; $display("FAIL single_data got=%h exp=a5a50001", xfer_data); end
    checks++; if (busy !== 1'b1 || src_ready !== 1'b0) begin failures++; $display("FAIL single_busy got=%b%b exp=10", busy, src_ready); end
    repeat (5) tick;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL single_wait got=%b%b exp=10", busy, done); end
    ack = 1'b1;
    repeat (2) tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_early_done got=%b exp=0", done); end
    tick;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", done); end
    checks++; if (src_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_free got=%b%b exp=10", src_ready, busy); end
    tick;
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL single_after got=%b%b exp=00", done, err); end
    exp_req = 1'b1;
  endtask
  task automatic test_back_to_back;
    int start_cnt;
    logic got;
    apply_reset;
    start_cnt = done_cnt;
    src_valid = 1'b1; src_data = 32'd1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      exp_req = ~exp_req;
      checks++; if (req !== exp_req) begin failures++; $display("FAIL b2b_req%0d got=%b exp=%b", i, req, exp_req); end
      checks++; if (xfer_data !== 32'(i)) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, xfer_data, i); end
      src_data = 32'(i + 1);
      repeat (3) tick;
      ack = exp_req;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        tick;
        checks++; if (xfer_data !== 32'(i)) begin failures++; $display("FAIL b2b_hold%0d got=%h exp=%h", i, xfer_data, i); end
        if (done === 1'b1) got = 1'b1;
      end
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL b2b_done%0d got=timeout exp=done", i); end
      checks++; if (src_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, src_ready); end
      if (i == 3) src_valid = 1'b0;
    end
    repeat (4) tick;
    checks++; if (done_cnt - start_cnt !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", done_cnt - start_cnt); end
    checks++; if (req !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL b2b_final got=%b%b%b exp=100", req, busy, err); end
  endtask
  task automatic test_data_hold;
    logic got;
    src_valid = 1'b1; src_data = 32'h1111_0000;
    tick;
    exp_req = ~exp_req;
    for (int i = 0; i < 6; i++) begin
      src_data = $urandom;
      tick;
      checks++; if (xfer_data !== 32'h1111_0000 || req !== exp_req) begin failures++; $display("FAIL hold%0d got=%h/%b exp=11110000/%b", i, xfer_data, req, exp_req); end
    end
    src_valid = 1'b0;
    ack = exp_req;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin tick; if (done === 1'b1) got = 1'b1; end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL hold_done got=timeout exp=done"); end
  endtask
  task automatic test_spurious_ack;
    logic got;
    tick;
    ack = ~ack;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin tick; if (err === 1'b1) got = 1'b1; end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
    checks++; if (req !== exp_req || busy !== 1'b0) begin failures++; $display("FAIL err_req got=%b/%b exp=%b/0", req, busy, exp_req); end
    repeat (3) tick;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
    src_valid = 1'b1; src_data = 32'hCAFE_F00D;
    tick;
    src_valid = 1'b0;
    exp_req = ~exp_req;
    checks++; if (xfer_data !== 32'hCAFE_F00D || req !== exp_req) begin failures++; $display("FAIL err_xfer got=%h/%b exp=cafef00d/%b", xfer_data, req, exp_req); end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin tick; if (done === 1'b1) got = 1'b1; end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL err_xfer_done got=timeout exp=done"); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_still got=%b exp=1", err); end
  endtask
  task automatic test_reset_mid;
    int start_cnt;
    apply_reset;
    src_valid = 1'b1; src_data = 32'h0BAD_BEEF;
    tick;
    src_valid = 1'b0;
    repeat (2) tick;
    checks++; if (req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b%b exp=11", req, busy); end
    start_cnt = done_cnt;
    #2 resetn = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || busy !== 1'b0 || src_ready !== 1'b0) begin failures++; $display("FAIL mid_async got=%b%b%b exp=000", req, busy, src_ready); end
    @(posedge clk);
    #1 resetn = 1'b1;
    checks++; if (src_ready !== 1'b0) begin failures++; $display("FAIL mid_ready1 got=%b exp=0", src_ready); end
    tick;
    checks++; if (src_ready !== 1'b1) begin failures++; $display("FAIL mid_ready2 got=%b exp=1", src_ready); end
    repeat (3) tick;
    checks++; if (done_cnt !== start_cnt || req !== 1'b0) begin failures++; $display("FAIL mid_nodone got=%0d/%b exp=%0d/0", done_cnt, req, start_cnt); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_data_hold;
    test_spurious_ack;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
